frame_input_latch: RTL and testbench

FRAME_INPUT_LATCH -- requirements
Module: frame_input_latch

---
 rtl/game_pkg.sv | 41 ++++
 rtl/key_code_lut.sv | 28 ++
 rtl/frame_input_latch.sv | 142 ++++++++++++++
 tb/tb_frame_input_latch.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/game_pkg.sv
// Shared game definitions: key scan codes, command bit positions and the
// held-key vector index enumeration.
package game_pkg;

  localparam int unsigned KEY_CODE_W = 9;
  localparam int unsigned NUM_KEYS   = 10;
  localparam int unsigned CMD_W      = 4;

  // Scan codes; bit 8 marks an E0-extended code
  localparam logic [KEY_CODE_W-1:0] KC_W     = 9'h01D;
  localparam logic [KEY_CODE_W-1:0] KC_A     = 9'h01C;
  localparam logic [KEY_CODE_W-1:0] KC_S     = 9'h01B;
  localparam logic [KEY_CODE_W-1:0] KC_D     = 9'h023;
  localparam logic [KEY_CODE_W-1:0] KC_UP    = 9'h175;
  localparam logic [KEY_CODE_W-1:0] KC_LEFT  = 9'h16B;
  localparam logic [KEY_CODE_W-1:0] KC_DOWN  = 9'h172;
  localparam logic [KEY_CODE_W-1:0] KC_RIGHT = 9'h174;
  localparam logic [KEY_CODE_W-1:0] KC_ENTER = 9'h05A;
  localparam logic [KEY_CODE_W-1:0] KC_Z     = 9'h01A;

  // Bit positions inside a {down,right,left,up} command nibble
  localparam int unsigned CMD_UP    = 0;
  localparam int unsigned CMD_LEFT  = 1;
  localparam int unsigned CMD_RIGHT = 2;
  localparam int unsigned CMD_DOWN  = 3;

  // Positions of each tracked key inside the held vector
  typedef enum logic [3:0] {
    KI_W     = 4'd0,
    KI_A     = 4'd1,
    KI_S     = 4'd2,
    KI_D     = 4'd3,
    KI_UP    = 4'd4,
    KI_LEFT  = 4'd5,
    KI_DOWN  = 4'd6,
    KI_RIGHT = 4'd7,
    KI_ENTER = 4'd8,
    KI_Z     = 4'd9
  } key_idx_e;

endpackage

// File: rtl/key_code_lut.sv
// Combinational scan-code to one-hot key index decoder; unmatched codes
// give an all-zero vector.
module key_code_lut
  import game_pkg::*;
(
  input  logic [KEY_CODE_W-1:0] i_key_code,
  output logic [NUM_KEYS-1:0]   o_onehot_c
);

  // Map each recognised code to its held-vector position
  always_comb begin
    o_onehot_c = '0;
    case (i_key_code)
      KC_W:     o_onehot_c[KI_W]     = 1'b1;
      KC_A:     o_onehot_c[KI_A]     = 1'b1;
      KC_S:     o_onehot_c[KI_S]     = 1'b1;
      KC_D:     o_onehot_c[KI_D]     = 1'b1;
      KC_UP:    o_onehot_c[KI_UP]    = 1'b1;
      KC_LEFT:  o_onehot_c[KI_LEFT]  = 1'b1;
      KC_DOWN:  o_onehot_c[KI_DOWN]  = 1'b1;
      KC_RIGHT: o_onehot_c[KI_RIGHT] = 1'b1;
      KC_ENTER: o_onehot_c[KI_ENTER] = 1'b1;
      KC_Z:     o_onehot_c[KI_Z]     = 1'b1;
      default:  o_onehot_c = '0;
    endcase
  end

endmodule

// File: rtl/frame_input_latch.sv
// Frame input latch: tracks held keys from a key-event stream and presents
// per-player commands that only change on the frame tick, plus start/pause
// controls. Optional feature macro: INPUT_STICKY_EN (tap capture of up
// presses so a press/release inside one frame is still seen).
module frame_input_latch
  import game_pkg::*;
#(
  parameter int unsigned STICKY_W = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  fps30,
  input  logic                  key_valid,
  input  logic [KEY_CODE_W-1:0] key_code,
  input  logic                  key_make,
  output logic [CMD_W-1:0]      p1_cmd,
  output logic [CMD_W-1:0]      p2_cmd,
  output logic                  p1_jump_evt,
  output logic                  p2_jump_evt,
  output logic                  frame_valid,
  output logic                  start_pulse,
  output logic                  pause
);

  logic [NUM_KEYS-1:0] w_key_oh;
  logic [NUM_KEYS-1:0] w_held_next;
  logic [NUM_KEYS-1:0] w_new_make;
  logic [NUM_KEYS-1:0] r_held;
  logic                r_prev_up_p1;
  logic                r_prev_up_p2;
  logic [STICKY_W-1:0] w_tap_p1;
  logic [STICKY_W-1:0] w_tap_p2;
  logic [CMD_W-1:0]    w_p1_next;
  logic [CMD_W-1:0]    w_p2_next;
  logic                w_p1_jump;
  logic                w_p2_jump;

  key_code_lut u_key_code_lut (
    .i_key_code (key_code),
    .o_onehot_c (w_key_oh)
  );

  // Next held vector and first-press (non-typematic) detection
  always_comb begin
    w_held_next = r_held;
    w_new_make  = '0;
    if (key_valid) begin
      if (key_make) begin
        w_held_next = r_held | w_key_oh;
        w_new_make  = w_key_oh & ~r_held;
      end else begin
        w_held_next = r_held & ~w_key_oh;
      end
    end
  end

  // Held-key state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_held <= '0;
    end else begin
      r_held <= w_held_next;
    end
  end

`ifdef INPUT_STICKY_EN
  logic [STICKY_W-1:0] r_tap_p1;
  logic [STICKY_W-1:0] r_tap_p2;

  // Include a press landing in the tick cycle in that tick's snapshot
  assign w_tap_p1 = r_tap_p1 | STICKY_W'(w_new_make[KI_W]);
  assign w_tap_p2 = r_tap_p2 | STICKY_W'(w_new_make[KI_UP]);

  // Tap capture: accumulate up presses, consumed by each snapshot
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_tap_p1 <= '0;
      r_tap_p2 <= '0;
    end else if (fps30) begin
      r_tap_p1 <= '0;
      r_tap_p2 <= '0;
    end else begin
      r_tap_p1 <= w_tap_p1;
      r_tap_p2 <= w_tap_p2;
    end
  end
`else
  assign w_tap_p1 = '0;
  assign w_tap_p2 = '0;
`endif

  // Snapshot candidates: left+right cancel, up/down pass through
  always_comb begin
    w_p1_next            = '0;
    w_p2_next            = '0;
    w_p1_next[CMD_UP]    = w_held_next[KI_W] | w_tap_p1[0];
    w_p1_next[CMD_LEFT]  = w_held_next[KI_A] & ~w_held_next[KI_D];
    w_p1_next[CMD_RIGHT] = w_held_next[KI_D] & ~w_held_next[KI_A];
    w_p1_next[CMD_DOWN]  = w_held_next[KI_S];
    w_p2_next[CMD_UP]    = w_held_next[KI_UP] | w_tap_p2[0];
    w_p2_next[CMD_LEFT]  = w_held_next[KI_LEFT] & ~w_held_next[KI_RIGHT];
    w_p2_next[CMD_RIGHT] = w_held_next[KI_RIGHT] & ~w_held_next[KI_LEFT];
    w_p2_next[CMD_DOWN]  = w_held_next[KI_DOWN];
    w_p1_jump = (w_held_next[KI_W] & ~r_prev_up_p1) | w_tap_p1[0];
    w_p2_jump = (w_held_next[KI_UP] & ~r_prev_up_p2) | w_tap_p2[0];
  end

  // Frame-stable outputs, refreshed only on the frame tick
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      p1_cmd       <= '0;
      p2_cmd       <= '0;
      p1_jump_evt  <= 1'b0;
      p2_jump_evt  <= 1'b0;
      r_prev_up_p1 <= 1'b0;
      r_prev_up_p2 <= 1'b0;
    end else if (fps30) begin
      p1_cmd       <= w_p1_next;
      p2_cmd       <= w_p2_next;
      p1_jump_evt  <= w_p1_jump;
      p2_jump_evt  <= w_p2_jump;
      r_prev_up_p1 <= w_held_next[KI_W];
      r_prev_up_p2 <= w_held_next[KI_UP];
    end
  end

  // Frame strobe and immediate control outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      frame_valid <= 1'b0;
      start_pulse <= 1'b0;
      pause       <= 1'b0;
    end else begin
      frame_valid <= fps30;
      start_pulse <= w_new_make[KI_ENTER];
      if (w_new_make[KI_Z]) begin
        pause <= ~pause;
      end
    end
  end

endmodule

// File: tb/tb_frame_input_latch.sv
// Directed bench for frame_input_latch with a key-level reference model.
// Honours INPUT_STICKY_EN the same way the design does.
module tb_frame_input_latch;

  logic       clk;
  logic       rst;
  logic       fps30;
  logic       key_valid;
  logic [8:0] key_code;
  logic       key_make;
  logic [3:0] p1_cmd;
  logic [3:0] p2_cmd;
  logic       p1_jump_evt;
  logic       p2_jump_evt;
  logic       frame_valid;
  logic       start_pulse;
  logic       pause;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  // Reference model state, indexed by key name order W A S D Up Left Down Right Enter Z
  bit       m_held[10];
  bit       m_tap1, m_tap2, m_prev1, m_prev2;
  bit [3:0] m_p1, m_p2;
  bit       m_j1, m_j2, m_fv, m_st, m_pause;

  frame_input_latch #(.STICKY_W(1)) dut (
    .clk         (clk),
    .rst         (rst),
    .fps30       (fps30),
    .key_valid   (key_valid),
    .key_code    (key_code),
    .key_make    (key_make),
    .p1_cmd      (p1_cmd),
    .p2_cmd      (p2_cmd),
    .p1_jump_evt (p1_jump_evt),
    .p2_jump_evt (p2_jump_evt),
    .frame_valid (frame_valid),
    .start_pulse (start_pulse),
    .pause       (pause)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  function automatic int code_idx(input logic [8:0] c);
    case (c)
      9'h01D: return 0;
      9'h01C: return 1;
      9'h01B: return 2;
      9'h023: return 3;
      9'h175: return 4;
      9'h16B: return 5;
      9'h172: return 6;
      9'h174: return 7;
      9'h05A: return 8;
      9'h01A: return 9;
      default: return -1;
    endcase
  endfunction

  task automatic model_clear();
    foreach (m_held[i]) m_held[i] = 1'b0;
    m_tap1 = 0; m_tap2 = 0; m_prev1 = 0; m_prev2 = 0;
    m_p1 = '0; m_p2 = '0; m_j1 = 0; m_j2 = 0;
    m_fv = 0; m_st = 0; m_pause = 0;
  endtask

  // Advance the model by one clock edge with the given inputs
  task automatic model_step(input bit fps, input bit kv, input logic [8:0] code, input bit mk);
    int  idx;
    bit  fresh;
    bit  sticky;
`ifdef INPUT_STICKY_EN
    sticky = 1'b1;
`else
    sticky = 1'b0;
`endif
    idx   = kv ? code_idx(code) : -1;
    fresh = (idx >= 0) && mk && !m_held[idx];
    m_st  = fresh && (idx == 8);
    if (fresh && idx == 9) m_pause = !m_pause;
    if (idx >= 0) m_held[idx] = mk;
    if (sticky && fresh && idx == 0) m_tap1 = 1'b1;
    if (sticky && fresh && idx == 4) m_tap2 = 1'b1;
    m_fv = fps;
    if (fps) begin
      m_p1 = {m_held[2], m_held[3] && !m_held[1], m_held[1] && !m_held[3], m_held[0] || m_tap1};
      m_p2 = {m_held[6], m_held[7] && !m_held[5], m_held[5] && !m_held[7], m_held[4] || m_tap2};
      m_j1 = (m_held[0] && !m_prev1) || m_tap1;
      m_j2 = (m_held[4] && !m_prev2) || m_tap2;
      m_prev1 = m_held[0];
      m_prev2 = m_held[4];
      m_tap1 = 0;
      m_tap2 = 0;
    end
  endtask

  task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @cyc %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  task automatic compare_all();
    check("p1_cmd", p1_cmd, m_p1);
    check("p2_cmd", p2_cmd, m_p2);
    check("p1_jump_evt", 4'(p1_jump_evt), 4'(m_j1));
    check("p2_jump_evt", 4'(p2_jump_evt), 4'(m_j2));
    check("frame_valid", 4'(frame_valid), 4'(m_fv));
    check("start_pulse", 4'(start_pulse), 4'(m_st));
    check("pause", 4'(pause), 4'(m_pause));
  endtask

  // One clock: drive inputs, take the edge, update model, compare after the edge
  task automatic step(input bit fps, input bit kv, input logic [8:0] code, input bit mk);
    fps30 = fps; key_valid = kv; key_code = code; key_make = mk;
    @(posedge clk);
    if (rst) model_step(fps, kv, code, mk);
    else model_clear();
    cyc++;
    #1;
    compare_all();
    fps30 = 0; key_valid = 0; key_make = 0; key_code = '0;
  endtask

  // Idle until cyc reaches n; key_make/key_code wiggle without key_valid
  task automatic run_to(input int n);
    while (cyc < n) step(1'b0, 1'b0, 9'h05A, 1'b1);
  endtask

  task automatic key(input logic [8:0] code, input bit mk);
    step(1'b0, 1'b1, code, mk);
  endtask

  task automatic tick();
    step(1'b1, 1'b0, 9'h000, 1'b0);
  endtask

  task automatic do_reset();
    #1;
    rst = 1'b0;
    fps30 = 0; key_valid = 0; key_make = 0; key_code = '0;
    model_clear();
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    cyc = 0;
  endtask

  initial begin
    rst = 1'b0; fps30 = 0; key_valid = 0; key_make = 0; key_code = '0;
    model_clear();
    #3;
    check("reset p1_cmd", p1_cmd, 4'h0);
    check("reset pause", 4'(pause), 4'h0);
    do_reset();

    // First tick after reset: zero snapshot, no spurious pulses
    run_to(4); tick();
    check("first frame_valid", 4'(frame_valid), 4'h1);
    check("first p1_jump", 4'(p1_jump_evt), 4'h0);

    // D make at 10, tick at 50 -> right on P1 at 51
    do_reset();
    run_to(10); key(9'h023, 1);
    run_to(50); tick();
    check("D p1_cmd", p1_cmd, 4'b0100);
    check("D frame_valid", 4'(frame_valid), 4'h1);
    run_to(60);
    check("frame_valid one cycle", 4'(frame_valid), 4'h0);

    // Left+Right cancel, then Right alone, then Left alone
    do_reset();
    key(9'h16B, 1); key(9'h174, 1); run_to(10); tick();
    check("LR p2_cmd", p2_cmd, 4'b0000);
    key(9'h16B, 0); key(9'h16B, 0); tick();
    check("R p2_cmd", p2_cmd, 4'b0100);
    key(9'h174, 0); key(9'h16B, 1);
    check("hold between frames", p2_cmd, 4'b0100);
    tick();
    check("L p2_cmd", p2_cmd, 4'b0010);

    // W make 5, break 20, tick 40, tick 60
    do_reset();
    run_to(5); key(9'h01D, 1);
    run_to(20); key(9'h01D, 0);
    run_to(40); tick();
`ifdef INPUT_STICKY_EN
    check("tap p1_cmd", p1_cmd, 4'b0001);
    check("tap p1_jump", 4'(p1_jump_evt), 4'h1);
`else
    check("tap p1_cmd", p1_cmd, 4'b0000);
    check("tap p1_jump", 4'(p1_jump_evt), 4'h0);
`endif
    run_to(60); tick();
    check("tap cleared p1_cmd", p1_cmd, 4'b0000);
    check("tap cleared p1_jump", 4'(p1_jump_evt), 4'h0);

    // Up held: jump once, typematic repeat gives no new jump
    do_reset();
    key(9'h175, 1); tick();
    check("up p2_cmd", p2_cmd, 4'b0001);
    check("up p2_jump", 4'(p2_jump_evt), 4'h1);
    key(9'h175, 1); key(9'h175, 1); tick();
    check("up repeat p2_jump", 4'(p2_jump_evt), 4'h0);
    check("up repeat p2_cmd", p2_cmd, 4'b0001);

    // Enter make 7, repeat make 9, then break: pulse only at 8
    do_reset();
    run_to(7); key(9'h05A, 1);
    check("start at 8", 4'(start_pulse), 4'h1);
    run_to(9); key(9'h05A, 1);
    key(9'h05A, 0);
    check("start quiet", 4'(start_pulse), 4'h0);

    // Two Z press/release pairs: pause 0 -> 1 -> 0
    do_reset();
    key(9'h01A, 1);
    check("pause on", 4'(pause), 4'h1);
    key(9'h01A, 0);
    check("pause kept on release", 4'(pause), 4'h1);
    key(9'h01A, 1);
    check("pause off", 4'(pause), 4'h0);
    key(9'h01A, 0);

    // A held, snapshot, then mid-frame reset clears everything immediately
    key(9'h01C, 1); tick();
    check("A p1_cmd", p1_cmd, 4'b0010);
    key(9'h01A, 1);
    #2;
    rst = 1'b0;
    #1;
    model_clear();
    check("async p1_cmd", p1_cmd, 4'h0);
    check("async pause", 4'(pause), 4'h0);
    compare_all();
    step(1'b0, 1'b0, 9'h000, 1'b0);
    rst = 1'b1;
    cyc = 0;
    run_to(5); tick();
    check("post reset p1_cmd", p1_cmd, 4'b0000);
    check("post reset frame_valid", 4'(frame_valid), 4'h1);

    // Key event coincident with tick is in that snapshot
    do_reset();
    run_to(3);
    step(1'b1, 1'b1, 9'h172, 1'b1);
    check("same-cycle p2_cmd", p2_cmd, 4'b1000);
    run_to(10);
    step(1'b1, 1'b1, 9'h172, 1'b0);
    check("same-cycle release", p2_cmd, 4'b0000);

    // Unrecognised codes are ignored
    key(9'h0AA, 1); key(9'h11D, 1); tick();
    check("ignored p1_cmd", p1_cmd, 4'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
